// File: rtl/pwm_pkg.sv
// Shared types and helpers for the count-driven PWM generator.
// Holds the default count width, the duty FSM state encoding and the
// duty saturation helper used by the handshake front end.
package pwm_pkg;

  localparam int CW_DEF = 4;
  localparam int DUTY_W = CW_DEF + 1;

  // Two-state duty FSM: no request waiting / request waiting for a wrap.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_PEND = 1'b1;

  // Clamp a requested duty to the full period length (2**cw counts).
  function automatic logic [31:0] sat_duty(input logic [31:0] d, input int unsigned cw);
    logic [31:0] lim;
    lim = 32'd1 << cw;
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/duty_shadow_reg.sv
// Duty request front end: valid/ready handshake, saturation and shadow register.
// A request is taken only while no other request is waiting; it stays pending
// until the next period_start strobe, at which point the top commits it.
module duty_shadow_reg
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          duty_valid,
  input  logic [CW:0]   duty_data,
  input  logic          period_start,
  output logic          duty_ready,
  output logic          pending,
  output logic [CW:0]   shadow,
  output state_t        state_o
);

  localparam int DW = CW + 1;

  // Handshake: a transfer happens on any clock edge where duty_valid and
  // duty_ready are both 1. duty_data must be stable while duty_valid is 1;
  // duty_ready only depends on internal state, never on duty_valid.

  state_t          state_q, state_d;
  logic [DW-1:0]   shadow_q, shadow_d;

  // Next-state: accept while idle, release the pending request on a wrap.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (duty_valid) begin
          shadow_d = DW'(sat_duty(32'(duty_data), CW));
          state_d  = ST_PEND;
        end
      end
      ST_PEND: begin
        if (period_start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and shadow registers; reset drops any pending request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  assign duty_ready = (state_q == ST_IDLE);
  assign pending    = (state_q == ST_PEND);
  assign shadow     = shadow_q;
  assign state_o    = state_q;

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an upstream free-running counter.
// Detects the count wrap, commits the shadowed duty glitch-free at the wrap,
// compares the count against the duty and registers pwm_out and period_tick.
// Optional build macro CNT_SEQ_CHECK_EN adds a sticky count sequence checker
// (count_err / err_clr); without it count_err is tied low.
module count_pwm_gen
  import pwm_pkg::*;
#(
  parameter int   CW  = CW_DEF,
  parameter logic POL = 1'b0
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [CW-1:0] count,
  input  logic          duty_valid,
  input  logic [CW:0]   duty_data,
  output logic          duty_ready,
  output logic          pwm_out,
  output logic          period_tick,
  input  logic          err_clr,
  output logic          count_err
);

  localparam int DW = CW + 1;

  logic          last_max_q;
  logic          period_start;
  logic          pending;
  logic [DW-1:0] shadow;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] duty_eff;
  logic          pwm_q, pwm_d;
  logic          tick_q;
  // FSM state tap, kept as a named net so checkers can bind to it here.
  state_t        unused_shadow_state;

  duty_shadow_reg #(
    .CW (CW)
  ) u_shadow (
    .clk          (clk),
    .clr_n        (clr_n),
    .duty_valid   (duty_valid),
    .duty_data    (duty_data),
    .period_start (period_start),
    .duty_ready   (duty_ready),
    .pending      (pending),
    .shadow       (shadow),
    .state_o      (unused_shadow_state)
  );

  // A period starts when the count returns to 0 right after its maximum, so a
  // held upstream clear (count stuck at 0) yields at most one start.
  assign period_start = last_max_q && (count == '0);

  // The pending duty takes effect on the very cycle it is committed.
  assign duty_eff = (period_start && pending) ? shadow : active_q;
  assign active_d = (period_start && pending) ? shadow : active_q;
  assign pwm_d    = ({1'b0, count} < duty_eff) ^ POL;

  // Wrap detector, active duty and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_max_q <= 1'b0;
      active_q   <= '0;
      pwm_q      <= POL;
      tick_q     <= 1'b0;
    end else begin
      last_max_q <= (count == '1);
      active_q   <= active_d;
      pwm_q      <= pwm_d;
      tick_q     <= period_start;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;

`ifdef CNT_SEQ_CHECK_EN
  logic [CW-1:0] prev_q;
  logic          chk_en_q;
  logic          err_q;
  logic          seq_bad;

  // A count of 0 is an upstream clear and is always legal.
  assign seq_bad = chk_en_q && (count != prev_q + CW'(1)) && (count != '0);

  // Sequence checker: the first post-reset cycle only primes prev_q; a new
  // error takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_q   <= '0;
      chk_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= count;
      chk_en_q <= 1'b1;
      if (seq_bad) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign count_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign count_err      = 1'b0;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// Bench for count_pwm_gen (CW=4, POL=0): directed stimulus, a behavioural
// period/duty model checked every cycle, and literal per-period expectations.
module tb_count_pwm_gen;

  logic       clk;
  logic       clr_n;
  logic [3:0] count;
  logic       duty_valid;
  logic [4:0] duty_data;
  logic       err_clr;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_tick;
  logic       count_err;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;
  bit hold_count = 0;

  // model state
  int m_active, m_shadow, m_lastcnt;
  bit m_pend, m_seen_cnt;
  int m_prev;
  bit m_started, m_err;
  bit exp_pwm, exp_tick, exp_ready, exp_err;

  count_pwm_gen #(.CW(4), .POL(1'b0)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .count       (count),
    .duty_valid  (duty_valid),
    .duty_data   (duty_data),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .err_clr     (err_clr),
    .count_err   (count_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a period begins when the count shows 0 right after 15;
  // a request waits for that start and then governs the whole new period.
  task automatic model_step();
    bit ps;
    int eff;
    if (!clr_n) begin
      m_active = 0; m_shadow = 0; m_pend = 0; m_lastcnt = 0; m_seen_cnt = 0;
      m_prev = 0; m_started = 0; m_err = 0;
      exp_pwm = 0; exp_tick = 0; exp_ready = 1; exp_err = 0;
    end else begin
      ps  = m_seen_cnt && (m_lastcnt == 15) && (count == 0);
      eff = (ps && m_pend) ? m_shadow : m_active;
      exp_pwm  = (int'(count) < eff);
      exp_tick = ps;
      if (m_pend) begin
        if (ps) begin
          m_active = m_shadow;
          m_pend   = 0;
        end
      end else if (duty_valid) begin
        m_shadow = (int'(duty_data) > 16) ? 16 : int'(duty_data);
        m_pend   = 1;
      end
      exp_ready = !m_pend;
`ifdef CNT_SEQ_CHECK_EN
      if (m_started && (int'(count) != ((m_prev + 1) % 16)) && (count != 0)) m_err = 1;
      else if (err_clr) m_err = 0;
      m_prev = int'(count);
      m_started = 1;
`endif
      exp_err = m_err;
      m_lastcnt  = int'(count);
      m_seen_cnt = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge clr_n);
    model_step();
  end

  // scoreboard compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("pwm_out", pwm_out, exp_pwm);
      chk("period_tick", period_tick, exp_tick);
      chk("duty_ready", duty_ready, exp_ready);
      chk("count_err", count_err, exp_err);
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
    if (!hold_count) count = count + 4'd1;
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 40; i++) begin
      if (int'(count) == c) return;
      cyc();
    end
    chk("run_to_timeout", int'(count), c);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 40; i++) begin
      if (period_tick) return;
      cyc();
    end
    chk("tick_timeout", 0, 1);
  endtask

  task automatic send_duty(input int d);
    duty_valid = 1'b1;
    duty_data  = 5'(d);
    cyc();
    duty_valid = 1'b0;
  endtask

  // count active cycles over one full period starting at the current tick
  task automatic measure(input string name, input int exp);
    int ones;
    wait_tick();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      ones += int'(pwm_out);
      cyc();
    end
    chk(name, ones, exp);
    chk({name, "_next_tick"}, int'(period_tick), 1);
  endtask

  task automatic load_and_measure(input string name, input int d, input int exp);
    run_to(3);
    send_duty(d);
    measure(name, exp);
  endtask

  initial begin
    int ticks;
    count = 4'd0; duty_valid = 1'b0; duty_data = 5'd0; err_clr = 1'b0;
    clr_n = 1'b0;
    repeat (3) cyc();
    chk("reset_pwm", pwm_out, 0);
    chk("reset_tick", period_tick, 0);
    chk("reset_ready", duty_ready, 1);
    chk("reset_err", count_err, 0);
    clr_n = 1'b1;
    cmp_en = 1'b1;

    // load: duty 5 accepted at count 3
    run_to(3);
    send_duty(5);
    chk("load_ready_low", duty_ready, 0);
    wait_tick();
    chk("load_ready_high", duty_ready, 1);
    measure("load_duty5", 5);

    // boundary: active 3, accept 8 on the period start cycle
    load_and_measure("duty3", 3, 3);
    run_to(0);
    duty_valid = 1'b1;
    duty_data  = 5'd8;
    cyc();
    duty_valid = 1'b0;
    chk("boundary_tick", period_tick, 1);
    measure("boundary_cur3", 3);
    measure("boundary_next8", 8);

    // extremes
    load_and_measure("duty0", 0, 0);
    load_and_measure("duty16", 16, 16);
    load_and_measure("duty20_sat", 20, 16);

    // held upstream clear: count stuck at 0 gives one start only
    run_to(0);
    hold_count = 1'b1;
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      ticks += int'(period_tick);
    end
    hold_count = 1'b0;
    chk("held_clear_ticks", ticks, 1);

    // mid-operation reset with duty 12 pending
    run_to(3);
    send_duty(12);
    run_to(8);
    chk("pre_reset_pwm", pwm_out, 1);
    clr_n = 1'b0;
    #1;
    chk("midrst_pwm", pwm_out, 0);
    chk("midrst_tick", period_tick, 0);
    chk("midrst_ready", duty_ready, 1);
    chk("midrst_err", count_err, 0);
    cyc();
    cyc();
    clr_n = 1'b1;
    cyc();
    chk("post_rst_ready", duty_ready, 1);
    measure("post_rst_duty0", 0);
    measure("post_rst_duty0_b", 0);

`ifdef CNT_SEQ_CHECK_EN
    run_to(7);
    @(posedge clk); #1; count = 4'd9;
    cyc();
    chk("seq_err_set", count_err, 1);
    cyc();
    cyc();
    chk("seq_err_hold", count_err, 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("seq_err_clear", count_err, 0);
    run_to(5);
    @(posedge clk); #1; count = 4'd0;
    cyc();
    cyc();
    chk("seq_zero_ok", count_err, 0);
`endif

    repeat (4) cyc();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
